dff_pipe: RTL and testbench

//  Parametrised elastic register pipeline: the multi-bit, multi-stage successor to the single dff.

---
 rtl/dff_pipe.sv | 100 ++++++++++
 tb/tb_dff_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// Elastic WIDTH-bit register pipeline of DEPTH stages with valid/ready flow control,
// bubble collapsing, synchronous flush and a running occupancy count.
module dff_pipe #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // Handshake: a word moves across a port on a rising edge where valid and
    // ready are both high; in_ready may depend combinationally on out_ready.
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_hs;
    logic             out_hs;

    // Advance chain is built last stage first; an empty stage always absorbs.
    always_comb begin
        logic run;
        run = out_ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            run    = !valid_q[i] || run;
            adv[i] = run;
        end
    end

    assign in_ready  = adv[0];
    assign in_hs     = in_valid && adv[0];
    assign out_valid = valid_q[DEPTH-1];
    assign out_hs    = valid_q[DEPTH-1] && out_ready;
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end

        if (adv[0]) begin
            valid_d[0] = in_hs;
            if (in_hs) begin
                data_d[0] = in_data;
            end
        end

        // Data only loads behind a valid word so bubbles never toggle the datapath.
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end

        occ_d = occ_q + OCC_W'(in_hs) - OCC_W'(out_hs);

        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RST_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=4): driver tasks push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_dff_pipe;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         flush;
    logic [2:0]   occupancy;

    logic [W-1:0] exp_q[$];
    int           errors;
    int           checks;
    int           hs_count;
    int           stalls;

    dff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver: offers one word, records it as expected once the pipe accepts it
    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                if (!flush) exp_q.push_back(d);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            stalls++;
        end
        errors++;
        checks++;
        $display("FAIL send_timeout actual=stalled required=accept data=%0h", d);
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($isunknown({in_ready, out_valid, out_data, occupancy})) begin
                errors++;
                $display("FAIL x_on_outputs actual=%b required=known",
                         {in_ready, out_valid, out_data, occupancy});
            end
            if (out_valid && out_ready) begin
                hs_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out actual=%0h required=none", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_data actual=%0h required=%0h", out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        errors    = 0;
        checks    = 0;
        hs_count  = 0;
        stalls    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        flush     = 1'b0;

        // reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        #20;
        rst_n = 1'b1;
        cycles(2);

        // latency: accepted at edge N, visible after edge N+3
        send(8'hA5);
        check("lat_occ_n", occupancy, 1);
        check("lat_valid_n", out_valid, 0);
        cycles(1);
        check("lat_valid_n1", out_valid, 0);
        cycles(1);
        check("lat_valid_n2", out_valid, 0);
        cycles(1);
        check("lat_valid_n3", out_valid, 1);
        check("lat_data_n3", out_data, 8'hA5);
        check("lat_occ_n3", occupancy, 1);
        cycles(2);
        check("lat_drained", occupancy, 0);

        // streaming 1..10 back-to-back
        base   = hs_count;
        stalls = 0;
        for (int k = 1; k <= 10; k++) send(W'(k));
        cycles(4);
        check("stream_stalls", stalls, 0);
        check("stream_out_count", hs_count - base, 10);
        check("stream_empty", out_valid, 0);

        // backpressure
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(W'(k));
        check("bp_occ_full", occupancy, 4);
        check("bp_in_ready_full", in_ready, 0);
        fork
            begin
                send(8'd5);
                send(8'd6);
            end
            begin
                cycles(3);
                check("bp_in_ready_held", in_ready, 0);
                check("bp_out_data_head", out_data, 8'd1);
                out_ready = 1'b1;
                cycles(1);
                check("bp_occ_accept_emit", occupancy, 4);
            end
        join
        cycles(8);
        check("bp_drained_occ", occupancy, 0);
        check("bp_drained_q", exp_q.size(), 0);

        // bubble collapse
        out_ready = 1'b0;
        send(8'h11);
        cycles(2);
        send(8'h22);
        cycles(4);
        check("bub_occ", occupancy, 2);
        check("bub_head", out_data, 8'h11);
        out_ready = 1'b1;
        cycles(1);
        check("bub_adjacent_valid", out_valid, 1);
        check("bub_adjacent_data", out_data, 8'h22);
        cycles(2);
        check("bub_drained", occupancy, 0);

        // flush drops in-flight words and the word offered at the flush edge
        out_ready = 1'b0;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        check("fl_occ_before", occupancy, 3);
        in_valid = 1'b1;
        in_data  = 8'h77;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("fl_occ", occupancy, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_out_data", out_data, 8'h00);
        check("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        cycles(6);
        send(8'h5C);
        cycles(5);
        check("fl_recover_q", exp_q.size(), 0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(8'hE1);
        send(8'hE2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 8'h00);
        check("mrst_occupancy", occupancy, 0);
        check("mrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycles(1);
        check("mrst_after_occ", occupancy, 0);
        check("mrst_after_valid", out_valid, 0);
        send(8'h9B);
        cycles(5);
        check("final_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
